mac_feeder: RTL and testbench

- Upstream driver for the 3-lane MAC. Collects three 24-bit pixel rows and three 24-bit weight rows of a 3x3 kernel window through a valid/ready input.
- Presents the rows to the MAC in lock-step with its free-running 4-phase frame, then captures the MAC's 20-bit signed result.
- Delivers that result through a valid/ready output.
- Sits between the window/line-buffer logic and the MAC instance.

---
 rtl/mac_pkg.sv | 44 ++++
 rtl/mac_feeder_if.sv | 36 +++
 rtl/mac_row_buffer.sv | 92 +++++++++
 rtl/mac_feeder.sv | 120 ++++++++++++
 tb/tb_mac_feeder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared widths, MAC phase numbering, feeder state encoding and the legal
// result range for the 3x3 kernel MAC feeder.
// No ports (package).
// -----------------------------------------------------------------------------
package mac_pkg;

   localparam int LANE_W     = 8;               // one pixel / weight lane
   localparam int LANES      = 3;               // lanes per row
   localparam int ROW_W      = LANES * LANE_W;  // 24-bit row word
   localparam int ROWS       = 3;               // rows per kernel window
   localparam int MAC_PHASES = 4;               // MAC frame length in cycles
   localparam int RES_W      = 20;              // signed MAC result width

   localparam int PH_W  = $clog2(MAC_PHASES);
   localparam int IDX_W = $clog2(ROWS);

   typedef logic [PH_W-1:0] phase_t;

   // Phase 0 clears the MAC accumulator, phases 1..3 accumulate rows 0..2.
   localparam phase_t PH_CLR = phase_t'(0);
   localparam phase_t PH_R0  = phase_t'(1);
   localparam phase_t PH_R1  = phase_t'(2);
   localparam phase_t PH_R2  = phase_t'(3);

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,   // accepting rows
      ST_ARMED = 2'd1,   // buffer full, waiting for a usable phase 0
      ST_ISSUE = 2'd2    // presenting rows during phases 1..3
   } feeder_state_e;

   // Extremes of a 3x3 window: 9 * 255 * -128 and 9 * 255 * 127.
   localparam int RES_MIN = -293760;
   localparam int RES_MAX = 291465;

   // Row index presented to the MAC in a given accumulate phase.
   function automatic logic [IDX_W-1:0] phase_to_row(input phase_t ph);
      phase_t diff;
      diff = ph - PH_R0;
      return IDX_W'(diff);
   endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// -----------------------------------------------------------------------------
// mac_feeder_if
// Bundles the three buses around the feeder:
//   row_*  : upstream valid/ready row input (pixels unsigned, weights signed)
//   mac_*  : words driven to the MAC and its registered result
//   res_*  : downstream valid/ready result output
// slave  : the feeder's view (consumes rows, drives MAC words and results)
// master : the surrounding logic's view (line buffer, MAC, result sink)
// -----------------------------------------------------------------------------
interface mac_feeder_if;
   import mac_pkg::*;

   logic             row_valid;
   logic             row_ready;
   logic [ROW_W-1:0] row_pix;
   logic [ROW_W-1:0] row_wgt;

   logic [ROW_W-1:0] mac_data;
   logic [ROW_W-1:0] mac_weight;
   logic [RES_W-1:0] mac_result;

   logic             res_valid;
   logic             res_ready;
   logic [RES_W-1:0] res_data;

   modport slave (
      input  row_valid, row_pix, row_wgt, mac_result, res_ready,
      output row_ready, mac_data, mac_weight, res_valid, res_data
   );

   modport master (
      output row_valid, row_pix, row_wgt, mac_result, res_ready,
      input  row_ready, mac_data, mac_weight, res_valid, res_data
   );

endinterface

// File: rtl/mac_row_buffer.sv
// -----------------------------------------------------------------------------
// mac_row_buffer
// Three-entry {pixel, weight} row store, written strictly in order 0,1,2.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   wr_en_i        write request (ignored while full)
//   wr_pix_i/_wgt_i  row words to store
//   clr_i          empty the buffer (pointer and full flag)
//   rd_idx_i       entry selected onto rd_pix_o / rd_wgt_o (combinational)
//   last_slot_o    next accepted write fills the buffer
//   full_o         all entries hold a row
// -----------------------------------------------------------------------------
module mac_row_buffer
   import mac_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [ROW_W-1:0] wr_pix_i,
   input  logic [ROW_W-1:0] wr_wgt_i,
   input  logic             clr_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [ROW_W-1:0] rd_pix_o,
   output logic [ROW_W-1:0] rd_wgt_o,
   output logic             last_slot_o,
   output logic             full_o
);

   logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
   logic             full_q, full_d;
   logic             wr_fire;
   logic [ROW_W-1:0] pix_arr [ROWS];
   logic [ROW_W-1:0] wgt_arr [ROWS];

   assign wr_fire     = wr_en_i && !full_q;
   assign last_slot_o = (wr_ptr_q == IDX_W'(ROWS-1));
   assign full_o      = full_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      full_d   = full_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         full_d   = 1'b0;
      end else if (wr_fire) begin
         if (last_slot_o) begin
            wr_ptr_d = '0;
            full_d   = 1'b1;
         end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         full_q   <= full_d;
      end
   end

   // Entry storage needs no reset: nothing reads it until it has been written.
   for (genvar gi = 0; gi < ROWS; gi++) begin : g_entry
      logic [ROW_W-1:0] pix_q;
      logic [ROW_W-1:0] wgt_q;

      always_ff @(posedge clk) begin
         if (wr_fire && (wr_ptr_q == IDX_W'(gi))) begin
            pix_q <= wr_pix_i;
            wgt_q <= wr_wgt_i;
         end
      end

      assign pix_arr[gi] = pix_q;
      assign wgt_arr[gi] = wgt_q;
   end

   always_comb begin
      rd_pix_o = '0;
      rd_wgt_o = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (rd_idx_i == IDX_W'(i)) begin
            rd_pix_o = pix_arr[i];
            rd_wgt_o = wgt_arr[i];
         end
      end
   end

endmodule

// File: rtl/mac_feeder.sv
// -----------------------------------------------------------------------------
// mac_feeder
// Collects three rows of a 3x3 window, replays them to the MAC in lock-step
// with its free-running 4-phase frame, captures the MAC sum and offers it
// downstream.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-low reset; the MAC must use ~rst so both phase
//         counters leave reset on the same edge
//   bus   mac_feeder_if.slave: row input, MAC words/result, result output
// -----------------------------------------------------------------------------
module mac_feeder
   import mac_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   mac_feeder_if.slave  bus
);

   phase_t           ph_q, ph_d;
   feeder_state_e    state_q;
   logic             frame_active_q;
   logic             capture_q;
   logic             res_valid_q;
   logic [RES_W-1:0] res_data_q;

   logic             buf_full, buf_last_slot;
   logic [ROW_W-1:0] buf_pix, buf_wgt;
   logic [IDX_W-1:0] rd_idx;
   logic             row_fire, frame_start, issue_last, res_pop, out_free;

   assign ph_d     = ph_q + 1'b1;   // free-running, wraps 3 -> 0
   assign row_fire = bus.row_valid && !buf_full;
   assign res_pop  = res_valid_q && bus.res_ready;
   // A frame may start if its result will have somewhere to land: the output
   // register is empty or is being popped this very cycle.
   assign out_free    = !res_valid_q || bus.res_ready;
   assign frame_start = (state_q == ST_ARMED) && (ph_q == PH_CLR) && out_free;
   assign issue_last  = frame_active_q && (ph_q == PH_R2);
   assign rd_idx      = phase_to_row(ph_q);

   mac_row_buffer u_row_buffer (
      .clk         (clk),
      .rst         (rst),
      .wr_en_i     (bus.row_valid),
      .wr_pix_i    (bus.row_pix),
      .wr_wgt_i    (bus.row_wgt),
      .clr_i       (issue_last),
      .rd_idx_i    (rd_idx),
      .rd_pix_o    (buf_pix),
      .rd_wgt_o    (buf_wgt),
      .last_slot_o (buf_last_slot),
      .full_o      (buf_full)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         ph_q           <= PH_CLR;
         state_q        <= ST_FILL;
         frame_active_q <= 1'b0;
         capture_q      <= 1'b0;
         res_valid_q    <= 1'b0;
         res_data_q     <= '0;
      end else begin
         ph_q      <= ph_d;
         capture_q <= 1'b0;

         case (state_q)
            ST_FILL: begin
               // Arm on the edge that stores the third row so a full buffer
               // can already start on the very next phase 0.
               if (row_fire && buf_last_slot) begin
                  state_q <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (frame_start) begin
                  state_q        <= ST_ISSUE;
                  frame_active_q <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (ph_q == PH_R2) begin
                  state_q        <= ST_FILL;
                  frame_active_q <= 1'b0;
                  capture_q      <= 1'b1;   // MAC sum is valid in next phase 0
               end
            end
            default: begin
               state_q        <= ST_FILL;
               frame_active_q <= 1'b0;
            end
         endcase

         // capture_q is only ever set when the output register is empty
         // (a frame cannot start otherwise), so it never races a pop.
         if (capture_q) begin
            res_data_q  <= bus.mac_result;
            res_valid_q <= 1'b1;
         end else if (res_pop) begin
            res_valid_q <= 1'b0;
         end
      end
   end

   // MAC words follow the phase combinationally and are zero outside a frame.
   always_comb begin
      bus.mac_data   = '0;
      bus.mac_weight = '0;
      if (frame_active_q && (ph_q != PH_CLR)) begin
         bus.mac_data   = buf_pix;
         bus.mac_weight = buf_wgt;
      end
   end

   assign bus.row_ready = !buf_full;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_feeder.sv
// -----------------------------------------------------------------------------
// tb_mac_feeder
// Directed bench for mac_feeder with a behavioural 4-phase MAC attached.
// Expected results are hand-computed window dot products.
// -----------------------------------------------------------------------------
module tb_mac_feeder;
   import mac_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mac_feeder_if bus_if ();

   mac_feeder u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int ph       = 0;   // bench copy of the frame phase

   logic [23:0] rp [3];
   logic [23:0] rw [3];

   // Behavioural MAC: reset by ~rst, clear on phase 0, accumulate on 1..3,
   // result register left unreset.
   logic [1:0]              mph;
   logic signed [RES_W-1:0] acc;

   function automatic logic signed [RES_W-1:0] rowdot(input logic [23:0] p,
                                                      input logic [23:0] w);
      logic signed [RES_W-1:0] s;
      s = '0;
      for (int i = 0; i < 3; i++) begin
         s += $signed({1'b0, p[i*8 +: 8]}) * $signed(w[i*8 +: 8]);
      end
      return s;
   endfunction

   always @(posedge clk) begin
      if (!rst) mph <= 2'd0;
      else      mph <= mph + 2'd1;
      if (mph == 2'd0) acc <= '0;
      else             acc <= acc + rowdot(bus_if.mac_data, bus_if.mac_weight);
   end
   assign bus_if.mac_result = acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (!rst) ph = 0;
      else      ph = (ph + 1) % 4;
   endtask

   task automatic wait_ph(input int p);
      for (int k = 0; k < 4 && ph != p; k++) step();
   endtask

   task automatic push(input logic [23:0] p, input logic [23:0] w);
      bus_if.row_valid = 1'b1;
      bus_if.row_pix   = p;
      bus_if.row_wgt   = w;
      step();
      bus_if.row_valid = 1'b0;
   endtask

   task automatic load3();
      for (int r = 0; r < 3; r++) push(rp[r], rw[r]);
   endtask

   // Entered in the phase-0 cycle in which the frame starts; returns in the
   // phase-1 cycle where the result first shows.
   task automatic issue_check(input string tag, input logic [19:0] exp);
      check({tag, "_idle_data"}, bus_if.mac_data, 0);
      step();
      for (int r = 0; r < 3; r++) begin
         check($sformatf("%s_data%0d", tag, r), bus_if.mac_data, rp[r]);
         check($sformatf("%s_wgt%0d", tag, r), bus_if.mac_weight, rw[r]);
         step();
      end
      check({tag, "_vld_early"}, bus_if.res_valid, 0);
      step();
      check({tag, "_vld"}, bus_if.res_valid, 1);
      check({tag, "_res"}, bus_if.res_data, exp);
      $display("frame %s res_data=0x%05h", tag, bus_if.res_data);
   endtask

   logic [23:0] cp   [12];
   logic [23:0] cw   [12];
   logic [19:0] cexp [4];

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, nres, last;
      logic fire;

      rst = 1'b0;
      bus_if.row_valid = 1'b0;
      bus_if.row_pix   = '0;
      bus_if.row_wgt   = '0;
      bus_if.res_ready = 1'b1;
      step();
      step();

      // Reset state
      check("rst_res_valid", bus_if.res_valid, 0);
      check("rst_res_data", bus_if.res_data, 0);
      check("rst_row_ready", bus_if.row_ready, 1);
      check("rst_mac_data", bus_if.mac_data, 0);
      check("rst_mac_weight", bus_if.mac_weight, 0);
      rst = 1'b1;

      // Frame: all ones -> 9
      rp = '{24'h010101, 24'h010101, 24'h010101};
      rw = '{24'h010101, 24'h010101, 24'h010101};
      load3();
      check("ones_full_ready", bus_if.row_ready, 0);
      check("ones_armed_data", bus_if.mac_data, 0);
      step();
      issue_check("ones", 20'h00009);

      // Most negative window
      wait_ph(0);
      rp = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
      rw = '{24'h808080, 24'h808080, 24'h808080};
      load3();
      step();
      issue_check("min", 20'hB8480);

      // Most positive window
      wait_ph(0);
      rw = '{24'h7F7F7F, 24'h7F7F7F, 24'h7F7F7F};
      load3();
      step();
      issue_check("max", 20'h47289);

      // Backpressure: result held, second window waits armed
      wait_ph(0);
      bus_if.res_ready = 1'b0;
      rp = '{24'h010101, 24'h010101, 24'h010101};
      rw = '{24'h010101, 24'h010101, 24'h010101};
      load3();
      step();
      issue_check("bp_a", 20'h00009);
      rp = '{24'h030303, 24'h030303, 24'h030303};
      rw = '{24'hFDFDFD, 24'hFDFDFD, 24'hFDFDFD};
      load3();
      bus_if.row_valid = 1'b1;          // offered while full: must be ignored
      bus_if.row_pix   = 24'hFFFFFF;
      bus_if.row_wgt   = 24'h7F7F7F;
      for (int c = 0; c < 8; c++) begin
         check("bp_row_ready", bus_if.row_ready, 0);
         check("bp_mac_data", bus_if.mac_data, 0);
         check("bp_res_valid", bus_if.res_valid, 1);
         check("bp_res_hold", bus_if.res_data, 20'h00009);
         step();
      end
      bus_if.row_valid = 1'b0;
      bus_if.res_ready = 1'b1;          // pop and start in the same phase 0
      issue_check("bp_b", 20'hFFFAF);

      // Continuous stream of four windows
      cp = '{24'h030201, 24'h060504, 24'h090807,
             24'h020202, 24'h020202, 24'h020202,
             24'h0A0A0A, 24'h0A0A0A, 24'h0A0A0A,
             24'h000064, 24'h00C800, 24'hFF0000};
      cw = '{24'h010101, 24'h010101, 24'h010101,
             24'h030303, 24'hFFFFFF, 24'h000000,
             24'hFEFEFE, 24'hFEFEFE, 24'hFEFEFE,
             24'h000005, 24'h00FD00, 24'h020000};
      cexp = '{20'h0002D, 20'h0000C, 20'hFFF4C, 20'h0019A};
      idx  = 0;
      nres = 0;
      last = 0;
      for (int c = 0; c < 80 && nres < 4; c++) begin
         bus_if.row_valid = (idx < 12);
         bus_if.row_pix   = cp[idx % 12];
         bus_if.row_wgt   = cw[idx % 12];
         fire = bus_if.row_valid && bus_if.row_ready;
         step();
         if (fire) idx++;
         if (bus_if.res_valid) begin
            check($sformatf("cont_res%0d", nres), bus_if.res_data, cexp[nres]);
            if (nres > 0) check($sformatf("cont_gap%0d", nres), c - last, 8);
            $display("stream result %0d res_data=0x%05h cycle=%0d", nres, bus_if.res_data, c);
            last = c;
            nres++;
         end
      end
      bus_if.row_valid = 1'b0;
      check("cont_count", nres, 4);

      // Reset during phase 2 of an issue
      wait_ph(0);
      rp = '{24'h050505, 24'h050505, 24'h050505};
      rw = '{24'h010101, 24'h010101, 24'h010101};
      load3();
      step();
      step();
      check("abort_row0", bus_if.mac_data, 24'h050505);
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("abort_res_valid", bus_if.res_valid, 0);
      check("abort_row_ready", bus_if.row_ready, 1);
      check("abort_mac_data", bus_if.mac_data, 0);
      check("abort_res_data", bus_if.res_data, 0);
      for (int c = 0; c < 8; c++) begin
         check("abort_no_result", bus_if.res_valid, 0);
         check("abort_no_issue", bus_if.mac_data, 0);
         step();
      end
      $display("abort frame dropped, res_valid=%0d", bus_if.res_valid);

      // Partial buffer never issues; third row at phase 1 arms for 2 cycles
      wait_ph(3);
      rp = '{24'h040404, 24'h040404, 24'h040404};
      rw = '{24'h020202, 24'h020202, 24'h020202};
      push(rp[0], rw[0]);
      for (int c = 0; c < 4; c++) begin
         check("part_ready", bus_if.row_ready, 1);
         check("part_no_issue", bus_if.mac_data, 0);
         step();
      end
      push(rp[1], rw[1]);
      push(rp[2], rw[2]);               // accepted in phase 1
      check("late_full", bus_if.row_ready, 0);
      check("late_armed_ph2", bus_if.mac_data, 0);
      step();
      check("late_armed_ph3", bus_if.mac_data, 0);
      step();
      issue_check("late", 20'h00048);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
